key_debounce_multi: RTL and testbench

Parametrised N-channel key conditioner replacing per-button debouncer instances in the board top level. It synchronises raw button/switch inputs, debounces them against a sample strobe derived from the clock generator, and emits a debounced level plus one-cycle press, release and long-press pulses per channel. An optional auto-repeat feature generates periodic pulses while a key stays held. Outputs feed the game controller directly (reset/OK buttons, future menu keys).

---
 rtl/key_debounce_multi.sv | 186 ++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: 2-flop synchroniser, strobe-based debounce, press/release/long pulses.
// Define KEY_DEBOUNCE_REPEAT_EN to build the auto-repeat generator; otherwise key_repeat is held at 0.
module key_debounce_multi #(
    parameter int N          = 8,
    parameter int ACTIVE_LOW = 0,
    parameter int STABLE_CNT = 4,
    parameter int LONG_CNT   = 100,
    parameter int REPEAT_CNT = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic [N-1:0] key_raw,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long,
    output logic [N-1:0] key_repeat
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_CNT + 1);
    localparam logic [SW-1:0] STAB_LIM = SW'(STABLE_CNT);
    localparam logic [HW-1:0] HOLD_LIM = HW'(LONG_CNT);
    localparam logic [N-1:0]  INV_MASK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    logic [N-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]  level_q, level_d, press_q, press_d, release_q, release_d;
    logic [N-1:0]  long_q, long_d, repeat_q, repeat_d;
    logic [N-1:0]  toggle_s;
    logic [SW-1:0] stab_q [N];
    logic [SW-1:0] stab_d [N];
    logic [HW-1:0] hold_q [N];
    logic [HW-1:0] hold_d [N];
    logic [1:0]    state_q [N];
    logic [1:0]    state_d [N];

    // Polarity normalisation feeding the synchroniser chain
    always_comb begin
        sync1_d = key_raw ^ INV_MASK;
        sync2_d = sync1_q;
    end

    // Debounce: a level change is accepted after STABLE_CNT consecutive differing strobes
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        toggle_s  = '0;
        for (int i = 0; i < N; i++) begin
            stab_d[i] = stab_q[i];
            if (sample_en) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (stab_q[i] + SW'(1) == STAB_LIM) begin
                        stab_d[i]    = '0;
                        toggle_s[i]  = 1'b1;
                        level_d[i]   = ~level_q[i];
                        press_d[i]   = ~level_q[i];
                        release_d[i] = level_q[i];
                    end else begin
                        stab_d[i] = stab_q[i] + SW'(1);
                    end
                end else begin
                    stab_d[i] = '0;
                end
            end else begin
                stab_d[i] = stab_q[i];
            end
        end
    end

    // Hold counter and per-channel IDLE/PRESSED/LONG state; a releasing strobe never counts
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N; i++) begin
            hold_d[i]  = hold_q[i];
            state_d[i] = state_q[i];
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (sample_en && !toggle_s[i] && (hold_q[i] != HOLD_LIM)) begin
                hold_d[i] = hold_q[i] + HW'(1);
                long_d[i] = (hold_q[i] + HW'(1) == HOLD_LIM);
            end else begin
                hold_d[i] = hold_q[i];
            end
            case (state_q[i])
                ST_IDLE: begin
                    if (toggle_s[i]) state_d[i] = ST_PRESSED;
                    else             state_d[i] = ST_IDLE;
                end
                ST_PRESSED: begin
                    if (toggle_s[i])  state_d[i] = ST_IDLE;
                    else if (long_d[i]) state_d[i] = ST_LONG;
                    else              state_d[i] = ST_PRESSED;
                end
                ST_LONG: begin
                    if (toggle_s[i]) state_d[i] = ST_IDLE;
                    else             state_d[i] = ST_LONG;
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [RW-1:0] REP_LIM = RW'(REPEAT_CNT);
    logic [RW-1:0] rep_q [N];
    logic [RW-1:0] rep_d [N];

    // Repeat generator: counts strobes only while in LONG, pulsing every REPEAT_CNT strobes
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N; i++) begin
            rep_d[i] = rep_q[i];
            if ((state_q[i] == ST_LONG) && !toggle_s[i]) begin
                if (!sample_en) begin
                    rep_d[i] = rep_q[i];
                end else if (rep_q[i] + RW'(1) == REP_LIM) begin
                    rep_d[i]    = '0;
                    repeat_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end else begin
                rep_d[i] = '0;
            end
        end
    end

    // Repeat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    // Auto-repeat compiled out
    always_comb begin
        repeat_d = '0;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N; i++) begin
                stab_q[i]  <= '0;
                hold_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N; i++) begin
                stab_q[i]  <= stab_d[i];
                hold_q[i]  <= hold_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: expected pulse events are queued with the strobe
// number they must appear on; a monitor pops and compares every pulse the DUT emits.
module tb_key_debounce_multi;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [7:0] key_raw;
    logic [7:0] key_level, key_press, key_release, key_long, key_repeat;
    logic [7:0] raw_al;
    logic [7:0] level_al, press_al, release_al, long_al, repeat_al;

    typedef struct {
        int         strobe;
        int         kind;
        logic [7:0] vec;
    } exp_t;

    exp_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    strobe_no = 0;
    string kname [4] = '{"press", "release", "long", "repeat"};

    always #5 clk = ~clk;

    key_debounce_multi #(.N(8), .ACTIVE_LOW(0), .STABLE_CNT(4), .LONG_CNT(100), .REPEAT_CNT(20)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat)
    );

    key_debounce_multi #(.N(8), .ACTIVE_LOW(1), .STABLE_CNT(4), .LONG_CNT(100), .REPEAT_CNT(20)) dut_al (
        .clk(clk), .rst_n(rst_n), .sample_en(1'b1), .key_raw(raw_al),
        .key_level(level_al), .key_press(press_al), .key_release(release_al),
        .key_long(long_al), .key_repeat(repeat_al)
    );

    task automatic push_exp(input int s, input int k, input logic [7:0] v);
        exp_t e;
        e.strobe = s;
        e.kind   = k;
        e.vec    = v;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe: raw changes made before the call are through the synchroniser by the latching edge.
    task automatic strobe();
        repeat (3) @(posedge clk);
        #1;
        sample_en = 1'b1;
        strobe_no++;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic monitor();
        exp_t       e;
        logic [7:0] pv [4];
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                pv[0] = key_press;
                pv[1] = key_release;
                pv[2] = key_long;
                pv[3] = key_repeat;
                if ((pv[0] | pv[1]) !== 8'h00) begin
                    checks++;
                    if ((pv[0] & pv[1]) !== 8'h00) begin
                        errors++;
                        $display("FAIL press_release_exclusive: overlap %h, required 00", pv[0] & pv[1]);
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (pv[k] !== 8'h00) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_%s: got %h at strobe %0d, required no pulse", kname[k], pv[k], strobe_no);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.kind != k || e.vec !== pv[k] || e.strobe != strobe_no) begin
                                errors++;
                                $display("FAIL event_%s: got %s %h at strobe %0d, required %s %h at strobe %0d",
                                         kname[k], kname[k], pv[k], strobe_no, kname[e.kind], e.vec, e.strobe);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen (next at strobe %0d), required 0",
                     name, exp_q.size(), exp_q[0].strobe);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sample_en = 1'b0;
        key_raw   = 8'hFF;
        raw_al    = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_long, key_repeat} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {key_level, key_press, key_release, key_long, key_repeat});
        end
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (key_level !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_level: got %h, required 00", key_level);
        end
        push_exp(strobe_no + 4, 0, 8'hFF);
        repeat (4) strobe();
        idle(2);
        checks++;
        if (key_level !== 8'hFF) begin
            errors++;
            $display("FAIL held_through_reset_level: got %h, required ff", key_level);
        end
        check_drain("reset_press_drain");
        // asynchronous reset while all keys are pressed
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_level !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_level: got %h, required 00", key_level);
        end
        key_raw = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        checks++;
        if ({key_level, key_press, key_release} !== 24'h0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %h, required 0", {key_level, key_press, key_release});
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            key_raw[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            strobe();
        end
        checks++;
        if (key_level !== 8'h00) begin
            errors++;
            $display("FAIL bounce_level: got %h, required 00", key_level);
        end
        key_raw[0] = 1'b1;
        push_exp(strobe_no + 4, 0, 8'h01);
        repeat (4) strobe();
        idle(2);
        checks++;
        if (key_level !== 8'h01) begin
            errors++;
            $display("FAIL bounce_settled_level: got %h, required 01", key_level);
        end
        key_raw[0] = 1'b0;
        push_exp(strobe_no + 4, 1, 8'h01);
        repeat (4) strobe();
        idle(2);
        check_drain("bounce_drain");
    endtask

    task automatic test_release();
        key_raw[3] = 1'b1;
        push_exp(strobe_no + 4, 0, 8'h08);
        repeat (4) strobe();
        key_raw[3] = 1'b0;
        repeat (3) strobe();
        key_raw[3] = 1'b1;
        repeat (2) strobe();
        checks++;
        if (key_level !== 8'h08) begin
            errors++;
            $display("FAIL short_release_level: got %h, required 08", key_level);
        end
        key_raw[3] = 1'b0;
        push_exp(strobe_no + 4, 1, 8'h08);
        repeat (4) strobe();
        idle(2);
        checks++;
        if (key_level !== 8'h00) begin
            errors++;
            $display("FAIL release_level: got %h, required 00", key_level);
        end
        check_drain("release_drain");
    endtask

    task automatic test_long_press();
        int sp;
        key_raw[1] = 1'b1;
        sp = strobe_no + 4;
        push_exp(sp, 0, 8'h02);
        push_exp(sp + 100, 2, 8'h02);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        push_exp(sp + 120, 3, 8'h02);
        push_exp(sp + 140, 3, 8'h02);
        push_exp(sp + 160, 3, 8'h02);
`endif
        push_exp(sp + 164, 1, 8'h02);
        repeat (164) strobe();
        checks++;
        if (key_level !== 8'h02) begin
            errors++;
            $display("FAIL long_hold_level: got %h, required 02", key_level);
        end
        key_raw[1] = 1'b0;
        repeat (4) strobe();
        idle(2);
        checks++;
        if ({key_level, key_repeat} !== 16'h0) begin
            errors++;
            $display("FAIL long_after_release: got %h, required 0", {key_level, key_repeat});
        end
        check_drain("long_drain");
    endtask

    task automatic test_short_hold();
        int sp;
        key_raw[2] = 1'b1;
        sp = strobe_no + 4;
        push_exp(sp, 0, 8'h04);
        push_exp(sp + 54, 1, 8'h04);
        repeat (54) strobe();
        key_raw[2] = 1'b0;
        repeat (4) strobe();
        idle(2);
        check_drain("short_hold_drain");
    endtask

    task automatic test_back_to_back();
        key_raw = 8'hF0;
        push_exp(strobe_no + 4, 0, 8'hF0);
        repeat (4) strobe();
        key_raw = 8'h0F;
        push_exp(strobe_no + 4, 0, 8'h0F);
        push_exp(strobe_no + 4, 1, 8'hF0);
        repeat (4) strobe();
        key_raw = 8'h00;
        push_exp(strobe_no + 4, 1, 8'h0F);
        repeat (4) strobe();
        idle(2);
        check_drain("back_to_back_drain");
    endtask

    // Strobe held high: the press is registered on the 6th edge after the raw change
    // (2 sync + 4 strobes), i.e. it is high during the 7th clock cycle.
    task automatic test_active_low();
        logic [7:0] want;
        @(posedge clk);
        #1;
        raw_al[7] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            want = (c == 6) ? 8'h80 : 8'h00;
            checks++;
            if (press_al !== want) begin
                errors++;
                $display("FAIL active_low_press_c%0d: got %h, required %h", c, press_al, want);
            end
        end
        checks++;
        if (level_al !== 8'h80) begin
            errors++;
            $display("FAIL active_low_level: got %h, required 80", level_al);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_bounce();
        test_release();
        test_long_press();
        test_short_hold();
        test_back_to_back();
        test_active_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
